// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: FSM state encoding,
// parity and data-width codes, and small decode helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Code 2'b11 also means no parity.
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam logic [1:0] DB_5 = 2'b00;
   localparam logic [1:0] DB_6 = 2'b01;
   localparam logic [1:0] DB_7 = 2'b10;
   localparam logic [1:0] DB_8 = 2'b11;

   function automatic logic parity_enabled(input logic [1:0] par);
      return (par == PAR_EVEN) || (par == PAR_ODD);
   endfunction

   // Index of the final data bit: 4 for DB_5 up to 7 for DB_8.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] db);
      return 3'd4 + {1'b0, db};
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; full pushes and
// empty pops are ignored so the caller never corrupts the pointers.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic                           pop,
   input  logic [WIDTH-1:0]               din,
   output logic [WIDTH-1:0]               dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_reg == LW'(DEPTH));
   assign empty   = (level_reg == '0);
   assign level   = level_reg;
   assign dout    = mem[rd_ptr_reg];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter with per-frame configurable data width, parity
// and stop bits; frames are sent back to back while the FIFO holds data.
module uart_tx_framed
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 5210,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [7:0]                          in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [1:0]                          cfg_data_bits,
   input  logic [1:0]                          cfg_parity,
   input  logic                                cfg_stop2,
   output logic                                tx,
   output logic                                busy,
   output logic                                tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [7:0]    din_masked;
   logic [3:0]    n_bits;

   state_t        state_reg;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    bit_idx_reg;
   logic          stop_idx_reg;
   logic [7:0]    data_reg;
   logic [1:0]    db_reg;
   logic [1:0]    par_reg;
   logic          stop2_reg;
   logic          tx_reg;
   logic          busy_reg;
   logic          done_pend_reg;
   logic          tx_done_reg;

   logic          bit_end;
   logic          frame_end;
   logic          parity_bit;
   logic          tx_next;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid & ~fifo_full),
      .pop   (fifo_pop),
      .din   (in_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Unused high data bits are zeroed at pop so parity is a plain XOR-reduce.
   assign n_bits = 4'd5 + {2'b00, cfg_data_bits};
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_mask
         assign din_masked[gi] = fifo_dout[gi] & (4'(gi) < n_bits);
      end
   endgenerate

   assign in_ready   = ~fifo_full;
   assign tx         = tx_reg;
   assign busy       = busy_reg;
   assign tx_done    = tx_done_reg;
   assign bit_end    = (cnt_reg == CW'(CLK_DIV - 1));
   assign frame_end  = (state_reg == STOP) && bit_end && (stop_idx_reg || !stop2_reg);
   assign fifo_pop   = !fifo_empty && ((state_reg == IDLE) || frame_end);
   assign parity_bit = (^data_reg) ^ (par_reg == PAR_ODD);

   always_comb begin
      tx_next = 1'b1;
      case (state_reg)
         START:   tx_next = 1'b0;
         DATA:    tx_next = data_reg[bit_idx_reg];
         PARITY:  tx_next = parity_bit;
         default: tx_next = 1'b1;
      endcase
   end

   // The line and done pulse trail the state by one cycle, so tx_done lines
   // up with the end of the last stop bit as it appears on the wire.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         stop_idx_reg  <= 1'b0;
         data_reg      <= '0;
         db_reg        <= DB_8;
         par_reg       <= PAR_NONE;
         stop2_reg     <= 1'b0;
         tx_reg        <= 1'b1;
         busy_reg      <= 1'b0;
         done_pend_reg <= 1'b0;
         tx_done_reg   <= 1'b0;
      end else begin
         tx_reg        <= tx_next;
         done_pend_reg <= frame_end;
         tx_done_reg   <= done_pend_reg;
         if (fifo_pop) begin
            state_reg <= START;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            data_reg  <= din_masked;
            db_reg    <= cfg_data_bits;
            par_reg   <= cfg_parity;
            stop2_reg <= cfg_stop2;
         end else if (state_reg != IDLE) begin
            cnt_reg <= bit_end ? '0 : cnt_reg + CW'(1);
            if (bit_end) begin
               case (state_reg)
                  START: begin
                     state_reg   <= DATA;
                     bit_idx_reg <= '0;
                  end
                  DATA: begin
                     if (bit_idx_reg == last_bit_idx(db_reg)) begin
                        state_reg    <= parity_enabled(par_reg) ? PARITY : STOP;
                        stop_idx_reg <= 1'b0;
                     end else begin
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                     end
                  end
                  PARITY: begin
                     state_reg    <= STOP;
                     stop_idx_reg <= 1'b0;
                  end
                  STOP: begin
                     if (frame_end) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end else begin
                        stop_idx_reg <= 1'b1;
                     end
                  end
                  default: state_reg <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Self-checking bench for uart_tx_framed: accepted bytes are queued with their
// framing, and a line monitor decodes tx and tx_done against that queue.
module tb_uart_tx_framed;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 8;
   localparam int LW         = $clog2(FIFO_DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    cfg_data_bits = 2'b11;
   logic [1:0]    cfg_parity = 2'b00;
   logic          cfg_stop2 = 1'b0;
   logic          tx;
   logic          busy;
   logic          tx_done;
   logic [LW-1:0] fifo_level;

   uart_tx_framed #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop2     (cfg_stop2),
      .tx            (tx),
      .busy          (busy),
      .tx_done       (tx_done),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] db;
      logic [1:0] par;
      logic       stop2;
   } frame_t;

   frame_t sb[$];
   int     total = 0;
   int     bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference line image: start, N data bits LSB first, optional parity, stop bits.
   function automatic logic [11:0] frame_bits(input frame_t f);
      logic [11:0] b;
      int          k;
      logic        p;
      b    = '1;
      b[0] = 1'b0;
      k    = 1;
      p    = 1'b0;
      for (int i = 0; i < 5 + int'(f.db); i++) begin
         b[k] = f.data[i];
         p    = p ^ f.data[i];
         k++;
      end
      if (f.par == 2'b01) b[k] = p;
      else if (f.par == 2'b10) b[k] = ~p;
      return b;
   endfunction

   function automatic int frame_nbits(input frame_t f);
      int p;
      p = (f.par == 2'b01 || f.par == 2'b10) ? 1 : 0;
      return 1 + 5 + int'(f.db) + p + 1 + int'(f.stop2);
   endfunction

   // Line monitor, sampling on the falling edge.
   frame_t               mon_f;
   logic [11:0]          mon_bits;
   int                   mon_len = 0;
   int                   mon_off = 0;
   bit                   mon_active = 1'b0;
   logic [CLK_DIV-1:0]   mon_samp = '0;
   int                   cyc = 0;
   int                   done_cnt = 0;
   int                   starts[$];

   always @(negedge clk) begin
      cyc++;
      if (tx_done === 1'b1) done_cnt++;
      if (rst) begin
         mon_active = 1'b0;
      end else begin
         if (mon_active && mon_off == mon_len * CLK_DIV) begin
            chk($sformatf("tx_done_at_end_d%02h", mon_f.data), tx_done, 1);
            mon_active = 1'b0;
            $display("frame data=%02h bits=%0d par=%0d stop2=%0d done", mon_f.data,
                     5 + int'(mon_f.db), mon_f.par, mon_f.stop2);
         end
         if (!mon_active && tx !== 1'b1) begin
            if (sb.size() == 0) begin
               chk("start_without_data", tx, 1);
            end else begin
               mon_f      = sb.pop_front();
               mon_bits   = frame_bits(mon_f);
               mon_len    = frame_nbits(mon_f);
               mon_off    = 0;
               mon_active = 1'b1;
               starts.push_back(cyc);
            end
         end
         if (mon_active) begin
            mon_samp = {mon_samp[CLK_DIV-2:0], tx};
            if (mon_off % CLK_DIV == CLK_DIV - 1) begin
               chk($sformatf("bit%0d_d%02h", mon_off / CLK_DIV, mon_f.data),
                   mon_samp, {CLK_DIV{mon_bits[mon_off / CLK_DIV]}});
            end
            if (mon_off == mon_len * CLK_DIV - 1) begin
               chk($sformatf("tx_done_early_d%02h", mon_f.data), tx_done, 0);
            end
            mon_off++;
         end
      end
   end

   task automatic set_cfg(input logic [1:0] db, input logic [1:0] par, input logic s2);
      cfg_data_bits = db;
      cfg_parity    = par;
      cfg_stop2     = s2;
   endtask

   task automatic offer(input logic [7:0] d, output bit acc);
      @(negedge clk);
      acc      = in_ready;
      in_data  = d;
      in_valid = 1'b1;
      if (acc) begin
         sb.push_back(frame_t'{data: d, db: cfg_data_bits, par: cfg_parity, stop2: cfg_stop2});
      end
   endtask

   task automatic stop_offer();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < budget && !reached; i++) begin
         @(negedge clk);
         #1;
         if (!busy && !mon_active && sb.size() == 0) reached = 1'b1;
      end
      chk("idle_reached", reached, 1);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] db,
                             input logic [1:0] par, input logic s2);
      bit acc;
      int d0;
      d0 = done_cnt;
      set_cfg(db, par, s2);
      offer(d, acc);
      chk("accept", acc, 1);
      stop_offer();
      wait_idle(500);
      chk("done_count_single", done_cnt - d0, 1);
   endtask

   initial begin
      bit   acc;
      int   n_acc;
      int   d0;
      frame_t tbl[4];

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_done", tx_done, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 8N1 0xA5 with start-latency checks
      set_cfg(2'b11, 2'b00, 1'b0);
      d0 = done_cnt;
      offer(8'hA5, acc);
      chk("lat_accept", acc, 1);
      stop_offer();
      chk("lat_e0_tx", tx, 1);
      chk("lat_e0_level", fifo_level, 1);
      @(negedge clk);
      chk("lat_e1_tx", tx, 1);
      chk("lat_e1_busy", busy, 1);
      chk("lat_e1_level", fifo_level, 0);
      @(negedge clk);
      chk("lat_e2_tx_fall", tx, 0);
      wait_idle(500);
      chk("done_count_8n1", done_cnt - d0, 1);

      // Parity and width variants
      tbl[0] = frame_t'{data: 8'hA5, db: 2'b11, par: 2'b01, stop2: 1'b0};
      tbl[1] = frame_t'{data: 8'hA5, db: 2'b11, par: 2'b10, stop2: 1'b0};
      tbl[2] = frame_t'{data: 8'h1F, db: 2'b00, par: 2'b10, stop2: 1'b1};
      tbl[3] = frame_t'{data: 8'hFF, db: 2'b00, par: 2'b10, stop2: 1'b1};
      for (int i = 0; i < 4; i++) begin
         send_frame(tbl[i].data, tbl[i].db, tbl[i].par, tbl[i].stop2);
      end

      // Config change mid-frame: 8N1 completes, next frame goes out as 7E2
      set_cfg(2'b11, 2'b00, 1'b0);
      d0 = done_cnt;
      offer(8'h3C, acc);
      stop_offer();
      repeat (12) @(negedge clk);
      set_cfg(2'b10, 2'b01, 1'b1);
      offer(8'hC3, acc);
      chk("cfgchg_accept", acc, 1);
      stop_offer();
      wait_idle(500);
      chk("cfgchg_done_count", done_cnt - d0, 2);

      // Fill the FIFO behind a running frame; 9th byte must be rejected
      set_cfg(2'b11, 2'b00, 1'b0);
      starts.delete();
      d0 = done_cnt;
      offer(8'h11, acc);
      stop_offer();
      repeat (2) @(negedge clk);
      n_acc = 0;
      for (int i = 0; i < 9; i++) begin
         offer(8'(($urandom & 8'hFF) ^ i), acc);
         if (acc) n_acc++;
      end
      chk("fill_ninth_rejected", acc, 0);
      stop_offer();
      chk("fill_accepted", n_acc, 8);
      chk("fill_level", fifo_level, 8);
      chk("fill_in_ready_low", in_ready, 0);
      wait_idle(2000);
      chk("fill_done_count", done_cnt - d0, 9);
      chk("fill_frame_count", starts.size(), 9);
      for (int i = 1; i < starts.size(); i++) begin
         chk($sformatf("fill_gap%0d", i), starts[i] - starts[i-1], 10 * CLK_DIV);
      end

      // Reset during DATA with three bytes queued
      set_cfg(2'b11, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         offer(8'h50 + 8'(i), acc);
      end
      stop_offer();
      repeat (9) @(negedge clk);
      chk("abort_level_before", fifo_level, 3);
      d0 = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx", tx, 1);
      chk("abort_level", fifo_level, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 1);
      sb.delete();
      rst = 1'b0;
      repeat (60) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_idle_tx", tx, 1);
      chk("abort_idle_busy", busy, 0);

      // Random single frames
      for (int i = 0; i < 4; i++) begin
         send_frame(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
